// File: rtl/seg_disp_pkg.sv
// Shared constants, state type and width helper for the seven-segment display scheduler.
package seg_disp_pkg;

  localparam logic [3:0]  BLANK_CODE = 4'hF;
  localparam logic [3:0]  OVF_CODE   = 4'hE;
  localparam int unsigned BCD_DIGITS = 5;
  localparam int unsigned BCD_W      = 4 * BCD_DIGITS;

  typedef enum logic [1:0] {IDLE, CONVERT, LOAD, DWELL} state_e;

  // Ceiling log2, never less than 1 so it can size a vector directly.
  function automatic int unsigned clog2(input longint unsigned value);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 63; i++) begin
      if ((64'd1 << i) < value) r = i + 1;
    end
    return (r == 0) ? 1 : r;
  endfunction

endpackage

// File: rtl/seg_display_scheduler_if.sv
// Requester-side valid/ready bus shared by all display sources.
interface seg_display_scheduler_if #(
  parameter int unsigned N_REQ  = 4,
  parameter int unsigned DATA_W = 14
);
  logic [N_REQ-1:0]        req_valid;
  logic [N_REQ*DATA_W-1:0] req_data;
  logic [N_REQ-1:0]        req_ready;

  modport master (output req_valid, output req_data, input  req_ready);
  modport slave  (input  req_valid, input  req_data, output req_ready);
endinterface

// File: rtl/bin_to_bcd_seq.sv
// Sequential double-dabble converter: one shift-add-3 step per cycle, DATA_W cycles per value.
module bin_to_bcd_seq
  import seg_disp_pkg::*;
#(
  parameter int unsigned DATA_W = 14
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              go,
  input  logic [DATA_W-1:0] bin,
  output logic              done,
  output logic [BCD_W-1:0]  bcd
);

  localparam int unsigned SR_W  = BCD_W + DATA_W;
  localparam int unsigned CNT_W = clog2(DATA_W + 1);

  logic [SR_W-1:0]  sr_q,   sr_d;
  logic [CNT_W-1:0] cnt_q,  cnt_d;
  logic             run_q,  run_d;
  logic             done_q, done_d;

  function automatic logic [SR_W-1:0] dabble_step(input logic [SR_W-1:0] sr);
    logic [SR_W-1:0] t;
    t = sr;
    for (int unsigned n = 0; n < BCD_DIGITS; n++) begin
      if (t[DATA_W + 4*n +: 4] >= 4'd5) t[DATA_W + 4*n +: 4] = t[DATA_W + 4*n +: 4] + 4'd3;
    end
    return t << 1;
  endfunction

  // The go cycle performs the first iteration directly on the input value.
  always_comb begin
    sr_d   = sr_q;
    cnt_d  = cnt_q;
    run_d  = run_q;
    done_d = 1'b0;
    if (go) begin
      sr_d   = dabble_step({{BCD_W{1'b0}}, bin});
      cnt_d  = CNT_W'(DATA_W - 1);
      run_d  = (DATA_W > 1);
      done_d = (DATA_W == 1);
    end else if (run_q) begin
      sr_d  = dabble_step(sr_q);
      cnt_d = cnt_q - CNT_W'(1);
      if (cnt_q == CNT_W'(1)) begin
        run_d  = 1'b0;
        done_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sr_q   <= '0;
      cnt_q  <= '0;
      run_q  <= 1'b0;
      done_q <= 1'b0;
    end else begin
      sr_q   <= sr_d;
      cnt_q  <= cnt_d;
      run_q  <= run_d;
      done_q <= done_d;
    end
  end

  assign done = done_q;
  assign bcd  = sr_q[SR_W-1 -: BCD_W];

endmodule

// File: rtl/seg_display_scheduler.sv
// Round-robin scheduler sharing a 4-digit seven-segment display between several requesters,
// converting each accepted value to BCD and holding it for a minimum dwell time.
module seg_display_scheduler
  import seg_disp_pkg::*;
#(
  parameter int unsigned N_REQ        = 4,
  parameter int unsigned DATA_W       = 14,
  parameter int unsigned DWELL_CYCLES = 100_000_000,
  parameter bit          LZ_BLANK     = 1'b1
) (
  input  logic                     clk,
  input  logic                     rst,
  seg_display_scheduler_if.slave   req,
  output logic [3:0]               digit3,
  output logic [3:0]               digit2,
  output logic [3:0]               digit1,
  output logic [3:0]               digit0,
  output logic [clog2(N_REQ)-1:0]  src_id,
  output logic                     overflow,
  output logic                     busy
);

  localparam int unsigned ID_W  = clog2(N_REQ);
  localparam int unsigned DW_W  = clog2(DWELL_CYCLES + 1);
  localparam int unsigned CV_W  = clog2(DATA_W);
  localparam int unsigned CNT_W = (DW_W > CV_W) ? DW_W : CV_W;

  state_e            state_q, state_d;
  logic [ID_W-1:0]   ptr_q,   ptr_d;
  logic [DATA_W-1:0] data_q,  data_d;
  logic [ID_W-1:0]   id_q,    id_d;
  logic [CNT_W-1:0]  cnt_q,   cnt_d;
  logic              go_q,    go_d;
  logic [15:0]       dig_q,   dig_d;
  logic [ID_W-1:0]   src_q,   src_d;
  logic              ovf_q,   ovf_d;
  logic              busy_q,  busy_d;

  logic [ID_W-1:0]   grant_id_c;
  logic              grant_vld_c;
  logic [N_REQ-1:0]  ready_c;
  logic [DATA_W-1:0] sel_data_c;
  logic              xfer_c;
  logic              bcd_done;
  logic [BCD_W-1:0]  bcd;

  bin_to_bcd_seq #(.DATA_W(DATA_W)) u_bcd (
    .clk  (clk),
    .rst  (rst),
    .go   (go_q),
    .bin  (data_q),
    .done (bcd_done),
    .bcd  (bcd)
  );

  // Overflow shows OVF_CODE everywhere; otherwise optionally blank leading zeros above digit0.
  function automatic logic [15:0] fmt_digits(input logic [BCD_W-1:0] b);
    logic [3:0] b3, b2, b1, b0;
    logic       lz3, lz2, lz1;
    b3  = b[12 +: 4];
    b2  = b[8  +: 4];
    b1  = b[4  +: 4];
    b0  = b[0  +: 4];
    lz3 = LZ_BLANK && (b3 == 4'd0);
    lz2 = lz3 && (b2 == 4'd0);
    lz1 = lz2 && (b1 == 4'd0);
    if (b[16 +: 4] != 4'd0) return {4{OVF_CODE}};
    return {lz3 ? BLANK_CODE : b3, lz2 ? BLANK_CODE : b2, lz1 ? BLANK_CODE : b1, b0};
  endfunction

  // First valid requester at or after the round-robin pointer.
  always_comb begin
    grant_id_c  = '0;
    grant_vld_c = 1'b0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      if (!grant_vld_c && req.req_valid[ID_W'((32'(ptr_q) + k) % N_REQ)]) begin
        grant_vld_c = 1'b1;
        grant_id_c  = ID_W'((32'(ptr_q) + k) % N_REQ);
      end
    end
  end

  always_comb begin
    ready_c    = '0;
    sel_data_c = '0;
    if (state_q == IDLE && grant_vld_c) ready_c[grant_id_c] = 1'b1;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      if (grant_id_c == ID_W'(k)) sel_data_c = req.req_data[k*DATA_W +: DATA_W];
    end
  end

  assign xfer_c        = (state_q == IDLE) && grant_vld_c;
  assign req.req_ready = ready_c;

  // The shared counter times CONVERT first, then the dwell.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    data_d  = data_q;
    id_d    = id_q;
    cnt_d   = cnt_q;
    go_d    = 1'b0;
    dig_d   = dig_q;
    src_d   = src_q;
    ovf_d   = ovf_q;
    unique case (state_q)
      IDLE: begin
        if (xfer_c) begin
          data_d  = sel_data_c;
          id_d    = grant_id_c;
          ptr_d   = (grant_id_c == ID_W'(N_REQ - 1)) ? '0 : ID_W'(grant_id_c + ID_W'(1));
          cnt_d   = CNT_W'(DATA_W - 1);
          go_d    = 1'b1;
          state_d = CONVERT;
        end
      end
      CONVERT: begin
        if (cnt_q == '0) state_d = LOAD;
        else             cnt_d   = cnt_q - CNT_W'(1);
      end
      LOAD: begin
        if (bcd_done) begin
          dig_d   = fmt_digits(bcd);
          src_d   = id_q;
          ovf_d   = (bcd[16 +: 4] != 4'd0);
          cnt_d   = CNT_W'(DWELL_CYCLES - 1);
          state_d = DWELL;
        end
      end
      DWELL: begin
        if (cnt_q == '0) state_d = IDLE;
        else             cnt_d   = cnt_q - CNT_W'(1);
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      data_q  <= '0;
      id_q    <= '0;
      cnt_q   <= '0;
      go_q    <= 1'b0;
      dig_q   <= {4{BLANK_CODE}};
      src_q   <= '0;
      ovf_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      data_q  <= data_d;
      id_q    <= id_d;
      cnt_q   <= cnt_d;
      go_q    <= go_d;
      dig_q   <= dig_d;
      src_q   <= src_d;
      ovf_q   <= ovf_d;
      busy_q  <= busy_d;
    end
  end

  assign digit3   = dig_q[15:12];
  assign digit2   = dig_q[11:8];
  assign digit1   = dig_q[7:4];
  assign digit0   = dig_q[3:0];
  assign src_id   = src_q;
  assign overflow = ovf_q;
  assign busy     = busy_q;

endmodule

// File: tb/tb_seg_display_scheduler.sv
// Self-checking bench for seg_display_scheduler: randomized requests against a decimal/round-robin model.
module tb_seg_display_scheduler;
  import seg_disp_pkg::*;

  localparam int unsigned N_REQ   = 4;
  localparam int unsigned DATA_W  = 14;
  localparam int unsigned DWELL   = 8;
  localparam int unsigned SPACING = DATA_W + 2 + DWELL;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] digit3, digit2, digit1, digit0;
  logic [1:0] src_id;
  logic       overflow, busy;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  int model_ptr;
  int shown_val;

  seg_display_scheduler_if #(.N_REQ(N_REQ), .DATA_W(DATA_W)) itf ();

  seg_display_scheduler #(
    .N_REQ(N_REQ), .DATA_W(DATA_W), .DWELL_CYCLES(DWELL), .LZ_BLANK(1'b1)
  ) dut (
    .clk(clk), .rst(rst), .req(itf),
    .digit3(digit3), .digit2(digit2), .digit1(digit1), .digit0(digit0),
    .src_id(src_id), .overflow(overflow), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // What the display should show for a value: plain decimal, leading zeros blanked, E's above 9999.
  function automatic logic [15:0] exp_digits(input int v);
    int d[4];
    bit lead;
    logic [15:0] r;
    if (v < 0) return 16'hFFFF;
    if (v > 9999) return 16'hEEEE;
    d[3] = v / 1000; d[2] = (v / 100) % 10; d[1] = (v / 10) % 10; d[0] = v % 10;
    lead = 1'b1;
    r = '0;
    for (int i = 3; i >= 0; i--) begin
      if (lead && i > 0 && d[i] == 0) r[i*4 +: 4] = 4'hF;
      else begin r[i*4 +: 4] = 4'(d[i]); lead = 1'b0; end
    end
    return r;
  endfunction

  function automatic int model_grant(input logic [N_REQ-1:0] v, input int ptr);
    for (int k = 0; k < int'(N_REQ); k++) begin
      if (v[(ptr + k) % int'(N_REQ)]) return (ptr + k) % int'(N_REQ);
    end
    return -1;
  endfunction

  function automatic logic [15:0] obs_digits();
    return {digit3, digit2, digit1, digit0};
  endfunction

  task automatic do_xfer(input int id, input logic [DATA_W-1:0] val,
                         output bit ok, output logic [N_REQ-1:0] rdy);
    ok  = 1'b0;
    rdy = '0;
    @(negedge clk);
    itf.req_data[id*DATA_W +: DATA_W] = val;
    itf.req_valid[id] = 1'b1;
    for (int c = 0; c < 200; c++) begin
      #1;
      if (itf.req_ready != '0) begin
        rdy = itf.req_ready;
        ok  = (rdy[id] === 1'b1);
        break;
      end
      @(negedge clk);
    end
    @(posedge clk); #1;
    itf.req_valid[id] = 1'b0;
    if (ok) model_ptr = (id + 1) % int'(N_REQ);
  endtask

  task automatic wait_idle(output bit ok);
    ok = 1'b0;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk); #1;
      if (!busy) begin ok = 1'b1; break; end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    itf.req_valid = '0;
    itf.req_data  = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_ptr = 0;
    shown_val = -1;
    @(negedge clk); #1;
    n_checks++; if (obs_digits() !== 16'hFFFF) $display("FAIL reset_digits: got %h want ffff", obs_digits()); else n_pass++;
    n_checks++; if (itf.req_ready !== 4'b0) $display("FAIL reset_ready: got %b want 0000", itf.req_ready); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else n_pass++;
    n_checks++; if (overflow !== 1'b0) $display("FAIL reset_overflow: got %b want 0", overflow); else n_pass++;
    n_checks++; if (src_id !== 2'd0) $display("FAIL reset_src_id: got %0d want 0", src_id); else n_pass++;
  endtask

  task automatic test_latency();
    bit ok;
    logic [N_REQ-1:0] rdy;
    int exp_id;
    exp_id = model_grant(4'b0100, model_ptr);
    do_xfer(2, 14'd1234, ok, rdy);
    n_checks++; if (!ok || rdy !== 4'(1 << exp_id)) $display("FAIL lat_grant: got %b want %b", rdy, 4'(1 << exp_id)); else n_pass++;
    repeat (14) @(posedge clk); #1;
    n_checks++; if (obs_digits() !== exp_digits(shown_val)) $display("FAIL lat_early_digits: got %h want %h", obs_digits(), exp_digits(shown_val)); else n_pass++;
    @(posedge clk); #1;
    n_checks++; if (obs_digits() !== exp_digits(1234)) $display("FAIL lat_digits: got %h want %h", obs_digits(), exp_digits(1234)); else n_pass++;
    n_checks++; if (src_id !== 2'd2) $display("FAIL lat_src_id: got %0d want 2", src_id); else n_pass++;
    shown_val = 1234;
    repeat (7) @(posedge clk); #1;
    n_checks++; if (busy !== 1'b1) $display("FAIL lat_busy_dwell: got %b want 1", busy); else n_pass++;
    @(posedge clk); #1;
    n_checks++; if (busy !== 1'b0) $display("FAIL lat_busy_end: got %b want 0", busy); else n_pass++;
  endtask

  task automatic test_values();
    int vals[$];
    bit ok;
    logic [N_REQ-1:0] rdy;
    int id;
    vals = '{0, 7, 9999, 10000, 16383, 10, 100};
    for (int i = 0; i < 6; i++) vals.push_back(int'($urandom_range(0, 16383)));
    foreach (vals[i]) begin
      id = int'($urandom_range(0, N_REQ - 1));
      do_xfer(id, DATA_W'(vals[i]), ok, rdy);
      n_checks++; if (!ok || rdy !== 4'(1 << id)) $display("FAIL val_grant[%0d]: got %b want %b", vals[i], rdy, 4'(1 << id)); else n_pass++;
      wait_idle(ok);
      n_checks++; if (!ok) $display("FAIL val_idle_timeout[%0d]: busy %b want 0", vals[i], busy); else n_pass++;
      n_checks++; if (obs_digits() !== exp_digits(vals[i])) $display("FAIL val_digits[%0d]: got %h want %h", vals[i], obs_digits(), exp_digits(vals[i])); else n_pass++;
      n_checks++; if (overflow !== (vals[i] > 9999)) $display("FAIL val_overflow[%0d]: got %b want %b", vals[i], overflow, vals[i] > 9999); else n_pass++;
      n_checks++; if (src_id !== 2'(id)) $display("FAIL val_src_id[%0d]: got %0d want %0d", vals[i], src_id, id); else n_pass++;
      shown_val = vals[i];
    end
  endtask

  task automatic test_dwell_hold();
    bit ok;
    logic [N_REQ-1:0] rdy;
    logic [DATA_W-1:0] a, b;
    int exp_id;
    a = DATA_W'($urandom_range(0, 9999));
    b = DATA_W'($urandom_range(0, 9999));
    do_xfer(0, a, ok, rdy);
    n_checks++; if (!ok) $display("FAIL hold_grant: got %b want 0001", rdy); else n_pass++;
    itf.req_data[3*DATA_W +: DATA_W] = b;
    itf.req_valid[3] = 1'b1;
    for (int k = 1; k <= 23; k++) begin
      n_checks++; if (itf.req_ready !== 4'b0) $display("FAIL hold_ready[c%0d]: got %b want 0000", k, itf.req_ready); else n_pass++;
      if (k >= 16) begin
        n_checks++; if (obs_digits() !== exp_digits(int'(a))) $display("FAIL hold_digits[c%0d]: got %h want %h", k, obs_digits(), exp_digits(int'(a))); else n_pass++;
      end
      @(posedge clk); #1;
    end
    exp_id = model_grant(4'b1000, model_ptr);
    n_checks++; if (itf.req_ready !== 4'(1 << exp_id)) $display("FAIL hold_release: got %b want %b", itf.req_ready, 4'(1 << exp_id)); else n_pass++;
    @(posedge clk); #1;
    itf.req_valid[3] = 1'b0;
    model_ptr = (exp_id + 1) % int'(N_REQ);
    wait_idle(ok);
    n_checks++; if (!ok || obs_digits() !== exp_digits(int'(b))) $display("FAIL hold_second: got %h want %h", obs_digits(), exp_digits(int'(b))); else n_pass++;
    shown_val = int'(b);
  endtask

  task automatic test_round_robin();
    logic [N_REQ-1:0] vmask;
    logic [DATA_W-1:0] vals[N_REQ];
    int exp_id, last_cyc, n_grant, target;
    bit ok;
    for (int phase = 0; phase < 2; phase++) begin
      vmask  = (phase == 0) ? 4'b1111 : 4'b1101;
      target = (phase == 0) ? 5 : 3;
      @(negedge clk);
      for (int i = 0; i < int'(N_REQ); i++) begin
        if (phase == 0) vals[i] = DATA_W'($urandom_range(0, 16383));
        itf.req_data[i*DATA_W +: DATA_W] = vals[i];
      end
      itf.req_valid = vmask;
      n_grant  = 0;
      last_cyc = -1;
      for (int c = 0; c < 400 && n_grant < target; c++) begin
        #1;
        if (itf.req_ready != '0) begin
          exp_id = model_grant(vmask, model_ptr);
          n_checks++; if (itf.req_ready !== 4'(1 << exp_id)) $display("FAIL rr_grant[p%0d g%0d]: got %b want %b", phase, n_grant, itf.req_ready, 4'(1 << exp_id)); else n_pass++;
          n_checks++; if (obs_digits() !== exp_digits(shown_val)) $display("FAIL rr_digits[p%0d g%0d]: got %h want %h", phase, n_grant, obs_digits(), exp_digits(shown_val)); else n_pass++;
          if (last_cyc >= 0) begin
            n_checks++; if (cyc - last_cyc != int'(SPACING)) $display("FAIL rr_spacing[p%0d g%0d]: got %0d want %0d", phase, n_grant, cyc - last_cyc, SPACING); else n_pass++;
          end
          last_cyc  = cyc;
          model_ptr = (exp_id + 1) % int'(N_REQ);
          shown_val = int'(vals[exp_id]);
          n_grant++;
          @(posedge clk); #1;
          vals[exp_id] = DATA_W'($urandom_range(0, 16383));
          itf.req_data[exp_id*DATA_W +: DATA_W] = vals[exp_id];
        end
        @(negedge clk);
      end
      n_checks++; if (n_grant != target) $display("FAIL rr_count[p%0d]: got %0d want %0d", phase, n_grant, target); else n_pass++;
    end
    itf.req_valid = '0;
    wait_idle(ok);
    n_checks++; if (!ok || obs_digits() !== exp_digits(shown_val)) $display("FAIL rr_final: got %h want %h", obs_digits(), exp_digits(shown_val)); else n_pass++;
  endtask

  task automatic test_reset_mid();
    bit ok;
    logic [N_REQ-1:0] rdy;
    logic [DATA_W-1:0] v0;
    do_xfer(1, DATA_W'($urandom_range(0, 9999)), ok, rdy);
    n_checks++; if (!ok) $display("FAIL rmid_grant: got %b want 0010", rdy); else n_pass++;
    repeat (4) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    n_checks++; if (obs_digits() !== 16'hFFFF) $display("FAIL rmid_digits: got %h want ffff", obs_digits()); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL rmid_busy: got %b want 0", busy); else n_pass++;
    n_checks++; if (src_id !== 2'd0) $display("FAIL rmid_src_id: got %0d want 0", src_id); else n_pass++;
    @(negedge clk);
    rst = 1'b0;
    model_ptr = 0;
    shown_val = -1;
    for (int i = 0; i < int'(N_REQ); i++) itf.req_data[i*DATA_W +: DATA_W] = DATA_W'($urandom_range(0, 16383));
    v0 = itf.req_data[0 +: DATA_W];
    itf.req_valid = 4'b1111;
    #1;
    n_checks++; if (itf.req_ready !== 4'(1 << model_grant(4'b1111, model_ptr))) $display("FAIL rmid_first_grant: got %b want %b", itf.req_ready, 4'(1 << model_grant(4'b1111, model_ptr))); else n_pass++;
    @(posedge clk); #1;
    itf.req_valid = '0;
    wait_idle(ok);
    n_checks++; if (!ok || obs_digits() !== exp_digits(int'(v0))) $display("FAIL rmid_after: got %h want %h", obs_digits(), exp_digits(int'(v0))); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_latency();
    test_values();
    test_dwell_hold();
    test_round_robin();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
